// File: rtl/debounce_multi.sv
// -----------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel button/switch debouncer. Every channel owns a synchroniser
// chain, a stability counter and a four-state FSM. A new level is accepted
// only after STABLE_CYCLES consecutive enabled samples of the synchronised
// input disagree with the current debounced level. Shorter excursions are
// discarded silently.
//
// Parameters
//   CHANNELS      number of independent channels (>=1)
//   STABLE_CYCLES consecutive enabled samples needed to accept a level (>=2)
//   SYNC_STAGES   synchroniser flops per channel (>=2)
//   INIT_LEVEL    reset level of synchroniser, FSM and s
//
// Ports
//   clk    in   system clock, all flops on posedge
//   rst_n  in   synchronous active-low reset
//   en     in   sample enable (prescaler tick); tie high to count every cycle
//   b      in   raw asynchronous inputs, one bit per channel
//   s      out  debounced levels (registered)
//   rise   out  one-cycle strobe coincident with s[i] going 0->1
//   fall   out  one-cycle strobe coincident with s[i] going 1->0
//   busy   out  channel is checking a pending level change
// -----------------------------------------------------------------------------
module debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 8,
    parameter int SYNC_STAGES   = 2,
    parameter bit INIT_LEVEL    = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CHANNELS-1:0] b,
    output logic [CHANNELS-1:0] s,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_CHK_HI    = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_CHK_LO    = 2'd3
    } state_t;

    localparam state_t ST_INIT = INIT_LEVEL ? ST_STABLE_HI : ST_STABLE_LO;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            state_t                 state_q, state_d;
            logic [CNT_W-1:0]       cnt_q, cnt_d;
            logic                   s_q, s_d;
            logic                   rise_q, rise_d;
            logic                   fall_q, fall_d;
            logic                   bs;

            // The synchroniser runs every cycle regardless of en, so the
            // prescaler only affects how often the settled value is judged.
            assign sync_d = {sync_q[SYNC_STAGES-2:0], b[gi]};
            assign bs     = sync_q[SYNC_STAGES-1];

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                s_d     = s_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                if (en) begin
                    case (state_q)
                        ST_STABLE_LO: begin
                            if (bs) begin
                                state_d = ST_CHK_HI;
                                cnt_d   = CNT_ONE;
                            end
                        end
                        ST_CHK_HI: begin
                            if (!bs) begin
                                // Excursion too short: drop it without a strobe.
                                state_d = ST_STABLE_LO;
                                cnt_d   = '0;
                            end else if (cnt_q == CNT_LAST) begin
                                state_d = ST_STABLE_HI;
                                s_d     = 1'b1;
                                rise_d  = 1'b1;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end
                        ST_STABLE_HI: begin
                            if (!bs) begin
                                state_d = ST_CHK_LO;
                                cnt_d   = CNT_ONE;
                            end
                        end
                        ST_CHK_LO: begin
                            if (bs) begin
                                state_d = ST_STABLE_HI;
                                cnt_d   = '0;
                            end else if (cnt_q == CNT_LAST) begin
                                state_d = ST_STABLE_LO;
                                s_d     = 1'b0;
                                fall_d  = 1'b1;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end
                        default: begin
                            state_d = ST_INIT;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_q  <= {SYNC_STAGES{INIT_LEVEL}};
                    state_q <= ST_INIT;
                    cnt_q   <= '0;
                    s_q     <= INIT_LEVEL;
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    sync_q  <= sync_d;
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    s_q     <= s_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            assign s[gi]    = s_q;
            assign rise[gi] = rise_q;
            assign fall[gi] = fall_q;
            assign busy[gi] = (state_q == ST_CHK_HI) || (state_q == ST_CHK_LO);
        end
    endgenerate

endmodule

// File: tb/tb_debounce_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_multi
//
// Directed scenarios followed by a randomized phase. A reference model tracks,
// per channel, the debounced level and the length of the current run of
// enabled samples that disagree with it; a level is accepted when that run
// reaches STABLE_CYCLES. The input seen by that rule is the raw input delayed
// by SYNC_STAGES clock edges.
// -----------------------------------------------------------------------------
module tb_debounce_multi;

    localparam int CH   = 4;
    localparam int SC   = 8;
    localparam int SYNC = 2;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [CH-1:0] b;
    logic [CH-1:0] s, rise, fall, busy;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [CH-1:0] m_hist [SYNC];
    int            m_run  [CH];
    logic [CH-1:0] m_s, m_rise, m_fall, m_busy;

    debounce_multi #(
        .CHANNELS     (CH),
        .STABLE_CYCLES(SC),
        .SYNC_STAGES  (SYNC),
        .INIT_LEVEL   (1'b0)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .b    (b),
        .s    (s),
        .rise (rise),
        .fall (fall),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model with the inputs present at the
    // edge, then compare all outputs 1 time unit after the edge.
    task automatic tick(input string tag);
        logic [CH-1:0] bs;
        @(posedge clk);
        m_rise = '0;
        m_fall = '0;
        if (!rst_n) begin
            for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
            for (int c = 0; c < CH; c++) m_run[c] = 0;
            m_s = '0;
        end else begin
            bs = m_hist[SYNC-1];
            for (int c = 0; c < CH; c++) begin
                if (en) begin
                    if (bs[c] != m_s[c]) begin
                        m_run[c]++;
                        if (m_run[c] == SC) begin
                            m_s[c]    = bs[c];
                            m_rise[c] = bs[c];
                            m_fall[c] = !bs[c];
                            m_run[c]  = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
            end
            for (int k = SYNC - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = b;
        end
        for (int c = 0; c < CH; c++) m_busy[c] = (m_run[c] > 0);
        #1;
        chk({tag, ".s"},    s,    m_s);
        chk({tag, ".rise"}, rise, m_rise);
        chk({tag, ".fall"}, fall, m_fall);
        chk({tag, ".busy"}, busy, m_busy);
    endtask

    logic saw_busy;
    logic en0_strobe;

    initial begin
        for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
        for (int c = 0; c < CH; c++) m_run[c] = 0;
        m_s = '0; m_rise = '0; m_fall = '0; m_busy = '0;

        // 1. reset with all inputs high
        rst_n = 1'b0; en = 1'b1; b = 4'hF;
        tick("reset");
        tick("reset");
        chk("reset_s", s, 4'h0);
        chk("reset_busy", busy, 4'h0);
        rst_n = 1'b1; b = 4'h0;
        for (int i = 0; i < 4; i++) tick("idle");

        // 2. clean press on channel 0
        b[0] = 1'b1;
        for (int i = 0; i < 9; i++) tick("press");
        chk("press_s0_before", {3'b0, s[0]}, 4'h0);
        tick("press");
        chk("press_s0_at10", {3'b0, s[0]}, 4'h1);
        chk("press_rise0_at10", {3'b0, rise[0]}, 4'h1);
        tick("press");
        chk("press_rise0_after", {3'b0, rise[0]}, 4'h0);

        // 3. 7-cycle glitch on channel 1
        saw_busy = 1'b0;
        b[1] = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick("glitch");
            saw_busy |= busy[1];
        end
        b[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick("glitch");
            saw_busy |= busy[1];
        end
        chk("glitch_saw_busy", {3'b0, saw_busy}, 4'h1);
        chk("glitch_busy1_clear", {3'b0, busy[1]}, 4'h0);
        chk("glitch_s1", {3'b0, s[1]}, 4'h0);

        // 4. bounce on channel 2
        b[2] = 1'b1; tick("bounce");
        b[2] = 1'b0; tick("bounce");
        b[2] = 1'b1;
        for (int i = 0; i < 9; i++) tick("bounce");
        chk("bounce_s2_before", {3'b0, s[2]}, 4'h0);
        tick("bounce");
        chk("bounce_s2_at10", {3'b0, s[2]}, 4'h1);

        // 5. en pulses one cycle in four, channel 3 held high
        en0_strobe = 1'b0;
        b[3] = 1'b1;
        for (int i = 0; i < 48; i++) begin
            en = (i % 4 == 0);
            tick("engate");
            if (!en && (rise != 4'h0 || fall != 4'h0)) en0_strobe = 1'b1;
        end
        en = 1'b1;
        chk("engate_no_strobe_en0", {3'b0, en0_strobe}, 4'h0);
        chk("engate_s3", {3'b0, s[3]}, 4'h1);

        // 6. reset in the middle of a check on channel 0
        b[0] = 1'b0;
        for (int i = 0; i < 12; i++) tick("mid_pre");
        chk("mid_s0_low", {3'b0, s[0]}, 4'h0);
        b[0] = 1'b1;
        for (int i = 0; i < 5; i++) tick("mid_chk");
        rst_n = 1'b0; tick("mid_rst");
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) tick("mid_post");
        chk("mid_s0_before", {3'b0, s[0]}, 4'h0);
        tick("mid_post");
        chk("mid_s0_at10", {3'b0, s[0]}, 4'h1);

        // randomized phase: sticky inputs with occasional toggles
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 5) == 0) b[c] = ~b[c];
            en    = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 199) != 0);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
